// File: rtl/last_fetched_store_table.sv
// Last fetched store table: per store set, tag of youngest dispatched, not-yet-issued store.
// Latency: 1 cycle from dispatch bundle to registered dep_valid/dep_tag outputs.
// Backpressure: dispatch_stall holds outputs and blocks dispatch writes; flush overrides it.
// Optional feature macro: LFST_ISSUE_BYPASS_EN (same-cycle issue invalidate hides the entry).
module last_fetched_store_table #(
    parameter int LFST_WIDTH = 11,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispatch_stall,
    input  logic                  instr0_valid,
    input  logic                  instr0_is_store,
    input  logic [LFST_WIDTH-1:0] instr0_store_set_id,
    input  logic [TAG_WIDTH-1:0]  instr0_tag,
    input  logic                  instr1_valid,
    input  logic                  instr1_is_store,
    input  logic [LFST_WIDTH-1:0] instr1_store_set_id,
    input  logic [TAG_WIDTH-1:0]  instr1_tag,
    output logic                  instr0_dep_valid,
    output logic [TAG_WIDTH-1:0]  instr0_dep_tag,
    output logic                  instr1_dep_valid,
    output logic [TAG_WIDTH-1:0]  instr1_dep_tag,
    input  logic                  st_issue_valid,
    input  logic [LFST_WIDTH-1:0] st_issue_set_id,
    input  logic [TAG_WIDTH-1:0]  st_issue_tag,
    input  logic                  flush
);

    localparam int DEPTH = 1 << LFST_WIDTH;

    // Table storage. Valid bits reset asynchronously; tags are only meaningful
    // while the matching valid bit is set, so they carry no reset.
    logic [DEPTH-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q [DEPTH];

    // Set ID 0 is the "no dependency" set and never participates.
    logic id0_nz;
    logic id1_nz;
    logic iss_nz;

    // Dispatch-side writes, issue-side invalidate.
    logic wr0;
    logic wr1;
    logic iss_hit;

    // Issue bypass kills for each lookup slot.
    logic kill0;
    logic kill1;

    // Intra-bundle forward from slot 0 store to slot 1.
    logic fwd1;

    // Combinational lookup results, registered into the outputs.
    logic                 look0_vld;
    logic [TAG_WIDTH-1:0] look0_tag;
    logic                 look1_vld;
    logic [TAG_WIDTH-1:0] look1_tag;

    assign id0_nz = (instr0_store_set_id != '0);
    assign id1_nz = (instr1_store_set_id != '0);
    assign iss_nz = (st_issue_set_id != '0);

    // A flush cycle performs no dispatch update; stall suppresses it as well.
    assign wr0 = !flush && !dispatch_stall && instr0_valid && instr0_is_store && id0_nz;
    assign wr1 = !flush && !dispatch_stall && instr1_valid && instr1_is_store && id1_nz;

    // Only the store that still owns the entry may clear it; a younger store
    // that re-wrote the entry keeps it alive.
    assign iss_hit = st_issue_valid && iss_nz && valid_q[st_issue_set_id]
                     && (tag_q[st_issue_set_id] == st_issue_tag);

`ifdef LFST_ISSUE_BYPASS_EN
    // The issuing store is leaving this cycle, so a same-cycle lookup of its
    // entry is reported as already resolved.
    assign kill0 = iss_hit && (st_issue_set_id == instr0_store_set_id);
    assign kill1 = iss_hit && (st_issue_set_id == instr1_store_set_id);
`else
    // Lookups see the pre-invalidate entry; the consumer matches the returned
    // tag against the issue broadcast to release the dependency.
    assign kill0 = 1'b0;
    assign kill1 = 1'b0;
`endif

    assign fwd1 = instr0_valid && instr0_is_store && instr1_valid && id0_nz
                  && (instr0_store_set_id == instr1_store_set_id);

    // Table lookup for both slots, including the slot 0 -> slot 1 forward.
    always_comb begin
        look0_vld = 1'b0;
        look0_tag = '0;
        look1_vld = 1'b0;
        look1_tag = '0;

        if (instr0_valid && id0_nz && valid_q[instr0_store_set_id] && !kill0) begin
            look0_vld = 1'b1;
            look0_tag = tag_q[instr0_store_set_id];
        end

        if (fwd1) begin
            look1_vld = 1'b1;
            look1_tag = instr0_tag;
        end else if (instr1_valid && id1_nz && valid_q[instr1_store_set_id] && !kill1) begin
            look1_vld = 1'b1;
            look1_tag = tag_q[instr1_store_set_id];
        end
    end

    // Valid bits: flush clears everything; otherwise the dispatch writes are
    // issued after the invalidate so they win on a shared entry, and slot 1
    // is last so it wins over slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (iss_hit) begin
                valid_q[st_issue_set_id] <= 1'b0;
            end
            if (wr0) begin
                valid_q[instr0_store_set_id] <= 1'b1;
            end
            if (wr1) begin
                valid_q[instr1_store_set_id] <= 1'b1;
            end
        end
    end

    // Tag storage: written by dispatching stores, slot 1 last so it wins.
    always_ff @(posedge clk) begin
        if (wr0) begin
            tag_q[instr0_store_set_id] <= instr0_tag;
        end
        if (wr1) begin
            tag_q[instr1_store_set_id] <= instr1_tag;
        end
    end

    // Output registers: cleared on reset and flush, held while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr0_dep_valid <= 1'b0;
            instr0_dep_tag   <= '0;
            instr1_dep_valid <= 1'b0;
            instr1_dep_tag   <= '0;
        end else if (flush) begin
            instr0_dep_valid <= 1'b0;
            instr0_dep_tag   <= '0;
            instr1_dep_valid <= 1'b0;
            instr1_dep_tag   <= '0;
        end else if (!dispatch_stall) begin
            instr0_dep_valid <= look0_vld;
            instr0_dep_tag   <= look0_tag;
            instr1_dep_valid <= look1_vld;
            instr1_dep_tag   <= look1_tag;
        end
    end

endmodule

// File: tb/tb_last_fetched_store_table.sv
// Directed bench for last_fetched_store_table with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Build with +define+LFST_ISSUE_BYPASS_EN to exercise the bypass variant.
module tb_last_fetched_store_table;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dispatch_stall = 1'b0;
    logic        instr0_valid = 1'b0;
    logic        instr0_is_store = 1'b0;
    logic [10:0] instr0_store_set_id = '0;
    logic [5:0]  instr0_tag = '0;
    logic        instr1_valid = 1'b0;
    logic        instr1_is_store = 1'b0;
    logic [10:0] instr1_store_set_id = '0;
    logic [5:0]  instr1_tag = '0;
    logic        instr0_dep_valid;
    logic [5:0]  instr0_dep_tag;
    logic        instr1_dep_valid;
    logic [5:0]  instr1_dep_tag;
    logic        st_issue_valid = 1'b0;
    logic [10:0] st_issue_set_id = '0;
    logic [5:0]  st_issue_tag = '0;
    logic        flush = 1'b0;

    int total = 0;
    int bad = 0;

    last_fetched_store_table #(.LFST_WIDTH(11), .TAG_WIDTH(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dispatch_stall      (dispatch_stall),
        .instr0_valid        (instr0_valid),
        .instr0_is_store     (instr0_is_store),
        .instr0_store_set_id (instr0_store_set_id),
        .instr0_tag          (instr0_tag),
        .instr1_valid        (instr1_valid),
        .instr1_is_store     (instr1_is_store),
        .instr1_store_set_id (instr1_store_set_id),
        .instr1_tag          (instr1_tag),
        .instr0_dep_valid    (instr0_dep_valid),
        .instr0_dep_tag      (instr0_dep_tag),
        .instr1_dep_valid    (instr1_dep_valid),
        .instr1_dep_tag      (instr1_dep_tag),
        .st_issue_valid      (st_issue_valid),
        .st_issue_set_id     (st_issue_set_id),
        .st_issue_tag        (st_issue_tag),
        .flush               (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; leaves time 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one dispatch bundle (issue/flush/stall are driven separately).
    task automatic bundle(input logic v0, input logic s0, input logic [10:0] id0, input logic [5:0] t0,
                          input logic v1, input logic s1, input logic [10:0] id1, input logic [5:0] t1);
        instr0_valid        = v0;
        instr0_is_store     = s0;
        instr0_store_set_id = id0;
        instr0_tag          = t0;
        instr1_valid        = v1;
        instr1_is_store     = s1;
        instr1_store_set_id = id1;
        instr1_tag          = t1;
    endtask

    task automatic idle();
        bundle(1'b0, 1'b0, 11'd0, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        st_issue_valid  = 1'b0;
        st_issue_set_id = '0;
        st_issue_tag    = '0;
        flush           = 1'b0;
        dispatch_stall  = 1'b0;
    endtask

    task automatic issue(input logic [10:0] id, input logic [5:0] t);
        st_issue_valid  = 1'b1;
        st_issue_set_id = id;
        st_issue_tag    = t;
    endtask

    initial begin
        // Reset held across two edges, then released mid-cycle.
        idle();
        tick();
        tick();
        chk("reset_dep0", 32'(instr0_dep_valid), 32'd0);
        chk("reset_dep1", 32'(instr1_dep_valid), 32'd0);
        chk("reset_tag0", 32'(instr0_dep_tag), 32'd0);
        #2 rst = 1'b1;
        tick();

        // Load on empty set 5.
        bundle(1'b1, 1'b0, 11'd5, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("empty_set5_dep0", 32'(instr0_dep_valid), 32'd0);

        // Store set 5 tag 12, then loads in both slots.
        bundle(1'b1, 1'b1, 11'd5, 6'd12, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        bundle(1'b1, 1'b0, 11'd5, 6'd0, 1'b1, 1'b0, 11'd5, 6'd0);
        tick();
        chk("set5_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("set5_tag0", 32'(instr0_dep_tag), 32'd12);
        chk("set5_dep1", 32'(instr1_dep_valid), 32'd1);
        chk("set5_tag1", 32'(instr1_dep_tag), 32'd12);

        // Intra-bundle forward: store set 7 tag 3 in slot 0, load set 7 in slot 1.
        bundle(1'b1, 1'b1, 11'd7, 6'd3, 1'b1, 1'b0, 11'd7, 6'd0);
        tick();
        chk("fwd_dep1", 32'(instr1_dep_valid), 32'd1);
        chk("fwd_tag1", 32'(instr1_dep_tag), 32'd3);
        chk("fwd_dep0_table_empty", 32'(instr0_dep_valid), 32'd0);
        bundle(1'b1, 1'b0, 11'd7, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("set7_later_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("set7_later_tag0", 32'(instr0_dep_tag), 32'd3);

        // Store set 9 tag 4, matching issue clears it.
        bundle(1'b1, 1'b1, 11'd9, 6'd4, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        idle();
        issue(11'd9, 6'd4);
        tick();
        idle();
        bundle(1'b1, 1'b0, 11'd9, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("issue_match_dep0", 32'(instr0_dep_valid), 32'd0);

        // Re-dispatch, then non-matching issue tag 5 leaves the entry alone.
        bundle(1'b1, 1'b1, 11'd9, 6'd4, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        idle();
        issue(11'd9, 6'd5);
        tick();
        idle();
        bundle(1'b1, 1'b0, 11'd9, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("issue_nomatch_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("issue_nomatch_tag0", 32'(instr0_dep_tag), 32'd4);

        // Same cycle: slot 0 loads set 9, slot 1 stores set 9 tag 8, issue set 9 tag 4.
        bundle(1'b1, 1'b0, 11'd9, 6'd0, 1'b1, 1'b1, 11'd9, 6'd8);
        issue(11'd9, 6'd4);
        tick();
`ifdef LFST_ISSUE_BYPASS_EN
        chk("bypass_dep0", 32'(instr0_dep_valid), 32'd0);
`else
        chk("nobypass_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("nobypass_tag0", 32'(instr0_dep_tag), 32'd4);
`endif
        idle();
        bundle(1'b1, 1'b0, 11'd9, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("dispatch_wins_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("dispatch_wins_tag0", 32'(instr0_dep_tag), 32'd8);

        // Populate sets 2, 1 and 2047.
        bundle(1'b1, 1'b1, 11'd2, 6'd30, 1'b1, 1'b1, 11'd1, 6'd31);
        tick();
        bundle(1'b1, 1'b1, 11'd2047, 6'd32, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        bundle(1'b1, 1'b0, 11'd2047, 6'd0, 1'b1, 1'b0, 11'd1, 6'd0);
        tick();
        chk("set2047_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("set2047_tag0", 32'(instr0_dep_tag), 32'd32);
        chk("set1_dep1", 32'(instr1_dep_valid), 32'd1);
        chk("set1_tag1", 32'(instr1_dep_tag), 32'd31);

        // Flush cycle with a live lookup and a store that must not be written.
        bundle(1'b1, 1'b0, 11'd2, 6'd0, 1'b1, 1'b1, 11'd3, 6'd33);
        flush = 1'b1;
        tick();
        chk("flush_out_dep0", 32'(instr0_dep_valid), 32'd0);
        chk("flush_out_dep1", 32'(instr1_dep_valid), 32'd0);
        flush = 1'b0;
        bundle(1'b1, 1'b0, 11'd2, 6'd0, 1'b1, 1'b0, 11'd1, 6'd0);
        tick();
        chk("post_flush_set2", 32'(instr0_dep_valid), 32'd0);
        chk("post_flush_set1", 32'(instr1_dep_valid), 32'd0);
        bundle(1'b1, 1'b0, 11'd2047, 6'd0, 1'b1, 1'b0, 11'd3, 6'd0);
        tick();
        chk("post_flush_set2047", 32'(instr0_dep_valid), 32'd0);
        chk("post_flush_set3", 32'(instr1_dep_valid), 32'd0);
        bundle(1'b1, 1'b0, 11'd9, 6'd0, 1'b1, 1'b0, 11'd5, 6'd0);
        tick();
        chk("post_flush_set9", 32'(instr0_dep_valid), 32'd0);
        chk("post_flush_set5", 32'(instr1_dep_valid), 32'd0);

        // Set 0: no forward, no write, no dependency.
        bundle(1'b1, 1'b1, 11'd0, 6'd1, 1'b1, 1'b0, 11'd0, 6'd0);
        tick();
        chk("set0_nofwd_dep1", 32'(instr1_dep_valid), 32'd0);
        chk("set0_store_dep0", 32'(instr0_dep_valid), 32'd0);
        bundle(1'b1, 1'b0, 11'd0, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("set0_load_dep0", 32'(instr0_dep_valid), 32'd0);

        // Stall: outputs hold, stores are not written.
        bundle(1'b1, 1'b1, 11'd10, 6'd20, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        bundle(1'b1, 1'b0, 11'd10, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("set10_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("set10_tag0", 32'(instr0_dep_tag), 32'd20);
        dispatch_stall = 1'b1;
        bundle(1'b1, 1'b1, 11'd11, 6'd21, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("stall_hold_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("stall_hold_tag0", 32'(instr0_dep_tag), 32'd20);
        dispatch_stall = 1'b0;
        bundle(1'b1, 1'b0, 11'd11, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("stall_nowrite_set11", 32'(instr0_dep_valid), 32'd0);

        // Flush has priority over stall.
        bundle(1'b1, 1'b0, 11'd10, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("pre_flushstall_dep0", 32'(instr0_dep_valid), 32'd1);
        dispatch_stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_over_stall_dep0", 32'(instr0_dep_valid), 32'd0);
        idle();
        bundle(1'b1, 1'b0, 11'd10, 6'd0, 1'b0, 1'b0, 11'd0, 6'd0);
        tick();
        chk("flush_over_stall_set10", 32'(instr0_dep_valid), 32'd0);

        // Repopulate, then pull reset mid-stream while stalled.
        bundle(1'b1, 1'b1, 11'd10, 6'd22, 1'b1, 1'b1, 11'd12, 6'd23);
        tick();
        bundle(1'b1, 1'b0, 11'd10, 6'd0, 1'b1, 1'b0, 11'd12, 6'd0);
        tick();
        chk("prerst_dep0", 32'(instr0_dep_valid), 32'd1);
        chk("prerst_dep1", 32'(instr1_dep_valid), 32'd1);
        dispatch_stall = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("async_rst_dep0", 32'(instr0_dep_valid), 32'd0);
        chk("async_rst_dep1", 32'(instr1_dep_valid), 32'd0);
        chk("async_rst_tag0", 32'(instr0_dep_tag), 32'd0);
        tick();
        #2 rst = 1'b1;
        dispatch_stall = 1'b0;
        tick();
        tick();
        chk("postrst_set10", 32'(instr0_dep_valid), 32'd0);
        chk("postrst_set12", 32'(instr1_dep_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
